// File: rtl/hazard_scheduler_pkg.sv
// Shared types for the decode-stage hazard scheduler.
// Forward select codes, pipeline entry structs and the match rule.
package hazard_scheduler_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_E   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef struct packed {
        logic       v;
        logic [5:0] rd;
        logic       regw;
        logic       memrd;
        logic       fpu;
    } hz_entry_t;

    typedef struct packed {
        logic       v;
        logic [5:0] rd;
        logic       regw;
    } hz_wb_t;

    typedef enum logic {
        RUN,
        FPU_BUSY
    } hz_state_e;

    // Integer x0 never forwards; fp reg 0 (6'b100000) does.
    function automatic logic hz_match(logic [5:0] rs, hz_wb_t w);
        return w.v & w.regw & (rs == w.rd) & (rs != 6'b000000);
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode <-> hazard scheduler bundle.
// master = decode side, slave = scheduler side.
interface hazard_scheduler_if;
    import hazard_scheduler_pkg::*;

    logic       dec_valid;
    logic [5:0] dec_rs0;
    logic [5:0] dec_rs1;
    logic       dec_use0;
    logic       dec_use1;
    logic [5:0] dec_rd;
    logic       dec_regw;
    logic       dec_memrd;
    logic       dec_fpu;
    logic       flush;
    logic [1:0] forward0;
    logic [1:0] forward1;
    logic       stall_d;
    logic       stall_e;
    logic       bubble_e;

    modport master (
        output dec_valid, dec_rs0, dec_rs1, dec_use0, dec_use1,
        output dec_rd, dec_regw, dec_memrd, dec_fpu, flush,
        input  forward0, forward1, stall_d, stall_e, bubble_e
    );

    modport slave (
        input  dec_valid, dec_rs0, dec_rs1, dec_use0, dec_use1,
        input  dec_rd, dec_regw, dec_memrd, dec_fpu, flush,
        output forward0, forward1, stall_d, stall_e, bubble_e
    );

endinterface

// File: rtl/hazard_scheduler_fwd_sel.sv
// Per-operand forward select: E result beats M result beats regfile.
// e_match also feeds the load-use detector.
module hazard_fwd_sel
    import hazard_scheduler_pkg::*;
(
    input  logic [5:0] rs,
    input  logic       rs_use,
    input  hz_wb_t     e,
    input  hz_wb_t     m,
    output logic [1:0] select,
    output logic       e_match
);

    logic m_match;

    assign e_match = rs_use & hz_match(rs, e);
    assign m_match = rs_use & hz_match(rs, m);

    assign select = e_match ? FWD_E :
                    m_match ? FWD_M : FWD_REG;

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: forwarding, load-use and FPU stalls.
// Optional HAZARD_PERF_CNT_EN adds perf_stall / perf_fpu counters.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int FPU_LAT = 4
) (
    input  logic               clk,
    input  logic               rstn,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_fpu,
`endif
    hazard_scheduler_if.slave  hz
);

    localparam int CW = $clog2(FPU_LAT + 1);

    hz_entry_t   e_q, e_d;
    hz_wb_t      m_q, m_d;
    hz_wb_t      e_wb;
    logic [CW-1:0] cnt_q, cnt_d;
    hz_state_e   state;
    logic        busy;
    logic        hit0, hit1, load_use;
    logic [1:0]  sel0, sel1;
    logic        stall_d, stall_e, bubble_e;

    assign e_wb  = '{v: e_q.v, rd: e_q.rd, regw: e_q.regw};
    assign busy  = e_q.fpu & (cnt_q != '0);
    assign state = busy ? FPU_BUSY : RUN;

    hazard_fwd_sel u_fwd0 (
        .rs      (hz.dec_rs0),
        .rs_use  (hz.dec_use0),
        .e       (e_wb),
        .m       (m_q),
        .select  (sel0),
        .e_match (hit0)
    );

    hazard_fwd_sel u_fwd1 (
        .rs      (hz.dec_rs1),
        .rs_use  (hz.dec_use1),
        .e       (e_wb),
        .m       (m_q),
        .select  (sel1),
        .e_match (hit1)
    );

    assign load_use = hz.dec_valid & e_q.memrd & (hit0 | hit1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        e_d      = e_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        bubble_e = 1'b0;
        unique case (state)
            FPU_BUSY: begin
                stall_d = 1'b1;
                stall_e = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                m_d     = '0;
            end
            RUN: begin
                m_d = e_wb;
                if (hz.flush) begin
                    bubble_e = 1'b1;
                    e_d      = '0;
                end else if (load_use) begin
                    stall_d  = 1'b1;
                    bubble_e = 1'b1;
                    e_d      = '0;
                end else if (hz.dec_valid) begin
                    e_d = '{v: 1'b1, rd: hz.dec_rd, regw: hz.dec_regw,
                            memrd: hz.dec_memrd, fpu: hz.dec_fpu};
                    if (hz.dec_fpu) cnt_d = CW'(FPU_LAT - 1);
                end else begin
                    bubble_e = 1'b1;
                    e_d      = '0;
                end
            end
            default: begin
                e_d   = '0;
                m_d   = '0;
                cnt_d = '0;
            end
        endcase
    end

    // Outputs read as zero for as long as reset is held.
    assign hz.forward0 = rstn ? sel0 : FWD_REG;
    assign hz.forward1 = rstn ? sel1 : FWD_REG;
    assign hz.stall_d  = rstn & stall_d;
    assign hz.stall_e  = rstn & stall_e;
    assign hz.bubble_e = rstn & bubble_e;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall <= '0;
            perf_fpu   <= '0;
        end else begin
            if (stall_d) perf_stall <= perf_stall + 32'd1;
            if (busy)    perf_fpu   <= perf_fpu + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus
// random traffic against a slot-level pipeline model.
module tb_hazard_scheduler;

    localparam int FPU_LAT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    hazard_scheduler_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_fpu;
`endif

    hazard_scheduler #(.FPU_LAT(FPU_LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall (perf_stall),
        .perf_fpu   (perf_fpu),
`endif
        .hz         (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [5:0] rd;
        bit       regw;
        bit       memrd;
        bit       fpu;
    } ent_t;

    ent_t   me, mm;
    int     busy_left;
    int     tests = 0;
    int     fails = 0;
    int     m_stall, m_fpu;
    logic [1:0] o_f0, o_f1;
    logic   o_sd, o_se, o_be;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(bit [5:0] rs, ent_t e);
        return e.v && e.regw && rs == e.rd && rs != 6'd0;
    endfunction

    task automatic drive(bit v, bit [5:0] rs0, bit u0, bit [5:0] rs1,
                         bit u1, bit [5:0] rd, bit w, bit ld, bit fp,
                         bit fl);
        hz.dec_valid = v;
        hz.dec_rs0   = rs0;
        hz.dec_use0  = u0;
        hz.dec_rs1   = rs1;
        hz.dec_use1  = u1;
        hz.dec_rd    = rd;
        hz.dec_regw  = w;
        hz.dec_memrd = ld;
        hz.dec_fpu   = fp;
        hz.flush     = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check outputs mid-cycle, then advance the model.
    task automatic cyc(string tag);
        bit busy, h0e, h1e, h0m, h1m, lu, esd, ebe;
        bit [1:0] e0, e1;
        @(negedge clk);
        busy = busy_left > 0;
        h0e  = hz.dec_use0 && hit(hz.dec_rs0, me);
        h1e  = hz.dec_use1 && hit(hz.dec_rs1, me);
        h0m  = hz.dec_use0 && hit(hz.dec_rs0, mm);
        h1m  = hz.dec_use1 && hit(hz.dec_rs1, mm);
        e0   = h0e ? 2'd1 : h0m ? 2'd2 : 2'd0;
        e1   = h1e ? 2'd1 : h1m ? 2'd2 : 2'd0;
        lu   = !busy && hz.dec_valid && me.memrd && (h0e || h1e);
        esd  = busy || (lu && !hz.flush);
        ebe  = !busy && (hz.flush || lu || !hz.dec_valid);
        o_f0 = hz.forward0;
        o_f1 = hz.forward1;
        o_sd = hz.stall_d;
        o_se = hz.stall_e;
        o_be = hz.bubble_e;
        chk({tag, ".fwd0"}, 32'(o_f0), 32'(e0));
        chk({tag, ".fwd1"}, 32'(o_f1), 32'(e1));
        chk({tag, ".stall_d"}, 32'(o_sd), 32'(esd));
        chk({tag, ".stall_e"}, 32'(o_se), 32'(busy));
        chk({tag, ".bubble_e"}, 32'(o_be), 32'(ebe));
        @(posedge clk);
        if (esd) m_stall++;
        if (busy) m_fpu++;
        if (busy) begin
            busy_left--;
            mm.v = 0;
        end else begin
            mm = me;
            if (!hz.flush && !lu && hz.dec_valid) begin
                me = '{1'b1, hz.dec_rd, hz.dec_regw, hz.dec_memrd,
                       hz.dec_fpu};
                busy_left = hz.dec_fpu ? FPU_LAT - 1 : 0;
            end else begin
                me = '{default: 0};
            end
        end
        #1;
    endtask

    task automatic do_reset(string tag);
        rstn = 1'b0;
        #1;
        chk({tag, ".fwd0"}, 32'(hz.forward0), 0);
        chk({tag, ".fwd1"}, 32'(hz.forward1), 0);
        chk({tag, ".stall_d"}, 32'(hz.stall_d), 0);
        chk({tag, ".stall_e"}, 32'(hz.stall_e), 0);
        chk({tag, ".bubble_e"}, 32'(hz.bubble_e), 0);
        me = '{default: 0};
        mm = '{default: 0};
        busy_left = 0;
        m_stall = 0;
        m_fpu = 0;
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".perf_stall"}, perf_stall, 0);
        chk({tag, ".perf_fpu"}, perf_fpu, 0);
`endif
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] ps0, pf0, r;
        ps0 = 0;
        pf0 = 0;
        nop();
        do_reset("reset");

        // add x5, then consumers see E then M forwarding
        drive(1, 0, 0, 0, 0, 6'd5, 1, 0, 0, 0);
        cyc("t1.add");
        drive(1, 6'd5, 1, 0, 0, 6'd7, 1, 0, 0, 0);
        cyc("t1.useE");
        chk("t1.fwdE", 32'(o_f0), 1);
        drive(1, 6'd5, 1, 0, 0, 6'd8, 1, 0, 0, 0);
        cyc("t1.useM");
        chk("t1.fwdM", 32'(o_f0), 2);

        // lw x6 then use on rs1: one load-use stall
        drive(1, 0, 0, 0, 0, 6'd6, 1, 1, 0, 0);
        cyc("t2.lw");
        drive(1, 0, 0, 6'd6, 1, 6'd9, 1, 0, 0, 0);
        cyc("t2.lu");
        chk("t2.stall", 32'(o_sd), 1);
        chk("t2.bubble", 32'(o_be), 1);
        cyc("t2.after");
        chk("t2.fwdM", 32'(o_f1), 2);
        chk("t2.nostall", 32'(o_sd), 0);

        // fadd f3 then fmul f3: 3 busy cycles then E forwarding
`ifdef HAZARD_PERF_CNT_EN
        ps0 = perf_stall;
        pf0 = perf_fpu;
`endif
        drive(1, 0, 0, 0, 0, 6'b100011, 1, 0, 1, 0);
        cyc("t3.fadd");
        drive(1, 6'b100011, 1, 0, 0, 6'b100100, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("t3.busy");
            chk("t3.stall_e", 32'(o_se), 1);
            chk("t3.stall_d", 32'(o_sd), 1);
        end
        cyc("t3.issue");
        chk("t3.fwdE", 32'(o_f0), 1);
        chk("t3.free", 32'(o_se), 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("t3.perf_fpu", perf_fpu - pf0, 3);
        chk("t3.perf_stall", perf_stall - ps0, 3);
`endif
        nop();
        for (int i = 0; i < 4; i++) cyc("t3.drain");

        // x0 never forwards, f0 does
        drive(1, 0, 0, 0, 0, 6'd0, 1, 0, 0, 0);
        cyc("t4.x0");
        drive(1, 6'd0, 1, 0, 0, 6'b100000, 1, 0, 0, 0);
        cyc("t4.usex0");
        chk("t4.x0fwd", 32'(o_f0), 0);
        drive(1, 6'b100000, 1, 0, 0, 6'd1, 1, 0, 0, 0);
        cyc("t4.usef0");
        chk("t4.f0fwd", 32'(o_f0), 1);

        // flush beats load-use
        drive(1, 0, 0, 0, 0, 6'd9, 1, 1, 0, 0);
        cyc("t5.lw");
        drive(1, 6'd9, 1, 0, 0, 6'd10, 1, 0, 0, 1);
        cyc("t5.flush");
        chk("t5.bubble", 32'(o_be), 1);
        chk("t5.stall", 32'(o_sd), 0);

        // reset in the middle of an FPU op
        drive(1, 0, 0, 0, 0, 6'b100001, 1, 0, 1, 0);
        cyc("t5.fadd");
        drive(1, 6'b100001, 1, 0, 0, 6'd2, 1, 0, 0, 0);
        cyc("t5.busy");
        chk("t5.busy_e", 32'(o_se), 1);
        do_reset("t5.rst");
        cyc("t5.post");
        chk("t5.post_e", 32'(o_se), 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            drive(r[3:0] != 0,
                  {r[4], 3'b000, r[6:5]}, r[7],
                  {r[8], 3'b000, r[10:9]}, r[11],
                  {r[12], 3'b000, r[14:13]}, r[15],
                  r[17:16] == 0, r[20:18] == 0,
                  r[24:21] == 0);
            cyc("rnd");
        end

`ifdef HAZARD_PERF_CNT_EN
        chk("end.perf_stall", perf_stall, 32'(m_stall));
        chk("end.perf_fpu", perf_fpu, 32'(m_fpu));
`endif
        if (ps0 != pf0) $display("perf base %0d %0d", ps0, pf0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
